// File: rtl/goertzel_pkg.sv
// Shared types and fixed-point format for the Goertzel filter bank.
// Samples and results are carried as signed 32.32 values.
package goertzel_pkg;

  localparam int FW   = 64;
  localparam int FRAC = 32;
  localparam int PW   = 2 * FW;

  localparam logic signed [FW-1:0] ONE = 64'sh0000_0001_0000_0000;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ACC,
    F_RE,
    F_IM,
    F_P1,
    F_P2,
    OUT
  } state_t;

endpackage

// File: rtl/goertzel_bank_mult_sign.sv
// Signed 32.32 x 32.32 multiplier, combinational.
// Full 128-bit product, middle 64 bits kept (arithmetic truncation).
module mult_sign
  import goertzel_pkg::*;
(
  input  logic signed [FW-1:0] a,
  input  logic signed [FW-1:0] b,
  output logic signed [FW-1:0] p
);

  logic signed [PW-1:0] full;

  assign full = PW'(a) * PW'(b);
  assign p    = FW'(full >>> FRAC);

endmodule

// File: rtl/goertzel_bank.sv
// Goertzel filter bank: NF bins updated per sample, one shared
// multiplier, per-bin re/im/power read out over a valid/ready port.
module goertzel_bank
  import goertzel_pkg::*;
#(
  parameter int NF = 11,
  parameter int N  = 205,
  parameter int SW = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         coef_valid,
  input  logic [NF-1:0][FW-1:0]        alpha_i,
  input  logic [NF-1:0][FW-1:0]        cos_i,
  input  logic [NF-1:0][FW-1:0]        sin_i,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic signed [SW-1:0]         s_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(NF)-1:0]        out_bin,
  output logic                         out_last,
  output logic signed [FW-1:0]         out_re,
  output logic signed [FW-1:0]         out_im,
  output logic signed [FW-1:0]         out_pwr
);

  localparam int KW = $clog2(NF);
  localparam int CW = $clog2(N + 1);

  localparam logic [KW-1:0] KLAST = KW'(NF - 1);
  localparam logic [CW-1:0] NLAST = CW'(N - 1);

  state_t st;

  logic signed [FW-1:0] alpha_q [NF];
  logic signed [FW-1:0] cos_q   [NF];
  logic signed [FW-1:0] sin_q   [NF];
  logic signed [FW-1:0] s1      [NF];
  logic signed [FW-1:0] s2      [NF];

  logic signed [FW-1:0] x_q;
  logic signed [FW-1:0] re_q;
  logic signed [FW-1:0] im_q;
  logic signed [FW-1:0] p1_q;

  logic [KW-1:0] k;
  logic [CW-1:0] cnt;

  logic signed [FW-1:0] ma;
  logic signed [FW-1:0] mb;
  logic signed [FW-1:0] prod;
  logic signed [FW-1:0] xw;
  logic signed [FW-1:0] acc_s;

  assign xw    = FW'(s_data);
  assign acc_s = x_q + prod - s2[k];

  mult_sign u_mul (
    .a (ma),
    .b (mb),
    .p (prod)
  );

  // Multiplier operand select; each state owns the single product.
  always_comb begin
    ma = '0;
    mb = '0;
    unique case (st)
      ACC: begin
        ma = alpha_q[k];
        mb = s1[k];
      end
      F_RE: begin
        ma = s2[k];
        mb = cos_q[k];
      end
      F_IM: begin
        ma = s2[k];
        mb = sin_q[k];
      end
      F_P1: begin
        ma = re_q;
        mb = re_q;
      end
      F_P2: begin
        ma = im_q;
        mb = im_q;
      end
      default: ;
    endcase
  end

  // Sequencer: coefficient latch, per-sample bin sweep, per-bin readout.
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      s_ready   <= 1'b0;
      out_valid <= 1'b0;
      out_bin   <= '0;
      out_last  <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_pwr   <= '0;
      x_q       <= '0;
      re_q      <= '0;
      im_q      <= '0;
      p1_q      <= '0;
      k         <= '0;
      cnt       <= '0;
      for (int i = 0; i < NF; i++) begin
        alpha_q[i] <= '0;
        cos_q[i]   <= '0;
        sin_q[i]   <= '0;
        s1[i]      <= '0;
        s2[i]      <= '0;
      end
    end else begin
      unique case (st)
        IDLE: begin
          if (coef_valid) begin
            for (int i = 0; i < NF; i++) begin
              alpha_q[i] <= alpha_i[i];
              cos_q[i]   <= cos_i[i];
              sin_q[i]   <= sin_i[i];
            end
            s_ready <= 1'b1;
            st      <= WAIT;
          end
        end
        WAIT: begin
          if (s_valid) begin
            x_q     <= xw <<< FRAC;
            k       <= '0;
            s_ready <= 1'b0;
            st      <= ACC;
          end
        end
        ACC: begin
          s1[k] <= acc_s;
          s2[k] <= s1[k];
          if (k == KLAST) begin
            cnt <= cnt + 1'b1;
            k   <= '0;
            if (cnt == NLAST) begin
              st <= F_RE;
            end else begin
              s_ready <= 1'b1;
              st      <= WAIT;
            end
          end else begin
            k <= k + 1'b1;
          end
        end
        F_RE: begin
          re_q <= s1[k] - prod;
          st   <= F_IM;
        end
        F_IM: begin
          im_q <= prod;
          st   <= F_P1;
        end
        F_P1: begin
          p1_q <= prod;
          st   <= F_P2;
        end
        F_P2: begin
          out_pwr   <= p1_q + prod;
          out_re    <= re_q;
          out_im    <= im_q;
          out_bin   <= k;
          out_last  <= (k == KLAST);
          out_valid <= 1'b1;
          st        <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (k == KLAST) begin
              for (int i = 0; i < NF; i++) begin
                s1[i] <= '0;
                s2[i] <= '0;
              end
              cnt     <= '0;
              k       <= '0;
              s_ready <= 1'b1;
              st      <= WAIT;
            end else begin
              k  <= k + 1'b1;
              st <= F_RE;
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_goertzel_bank.sv
// Directed + randomized bench for goertzel_bank, NF=2 N=4.
// Bin0 is DC, bin1 is the quarter-rate tone; reference is a rotated sum.
module tb_goertzel_bank;
  import goertzel_pkg::*;

  localparam int NF = 2;
  localparam int N  = 4;
  localparam int SW = 16;

  logic                  clk;
  logic                  rst;
  logic                  coef_valid;
  logic [NF-1:0][FW-1:0] alpha_i;
  logic [NF-1:0][FW-1:0] cos_i;
  logic [NF-1:0][FW-1:0] sin_i;
  logic                  s_valid;
  logic                  s_ready;
  logic signed [SW-1:0]  s_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [0:0]            out_bin;
  logic                  out_last;
  logic signed [FW-1:0]  out_re;
  logic signed [FW-1:0]  out_im;
  logic signed [FW-1:0]  out_pwr;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int xs[4];
  int nwait;

  goertzel_bank #(.NF(NF), .N(N), .SW(SW)) dut (
    .clk        (clk),
    .rst        (rst),
    .coef_valid (coef_valid),
    .alpha_i    (alpha_i),
    .cos_i      (cos_i),
    .sin_i      (sin_i),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_bin    (out_bin),
    .out_last   (out_last),
    .out_re     (out_re),
    .out_im     (out_im),
    .out_pwr    (out_pwr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic good_coefs();
    alpha_i[0] = 64'h2_0000_0000;
    alpha_i[1] = 64'h0;
    cos_i[0]   = ONE;
    cos_i[1]   = 64'h0;
    sin_i[0]   = 64'h0;
    sin_i[1]   = ONE;
  endtask

  task automatic junk_coefs();
    for (int i = 0; i < NF; i++) begin
      alpha_i[i] = {$urandom, $urandom};
      cos_i[i]   = {$urandom, $urandom};
      sin_i[i]   = {$urandom, $urandom};
    end
  endtask

  // y_b = sum x[n] * e^{j*b*pi/2*(N-1-n)}, in integer units
  function automatic void model(input int x[4], input int b,
                                output longint re, output longint im);
    re = 0;
    im = 0;
    for (int n = 0; n < N; n++) begin
      case ((b * (N - 1 - n)) % 4)
        0: re += x[n];
        1: im += x[n];
        2: re -= x[n];
        default: im -= x[n];
      endcase
    end
  endfunction

  task automatic check_bin(input string tag, input int x[4], input int b);
    longint re, im;
    model(x, b, re, im);
    check($sformatf("%s_b%0d_bin", tag, b), 64'(out_bin), 64'(b));
    check($sformatf("%s_b%0d_last", tag, b), 64'(out_last),
          64'(b == NF - 1));
    check($sformatf("%s_b%0d_re", tag, b), out_re, 64'(re) << 32);
    check($sformatf("%s_b%0d_im", tag, b), out_im, 64'(im) << 32);
    check($sformatf("%s_b%0d_pwr", tag, b), out_pwr,
          64'(re * re + im * im) << 32);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (out_valid !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
  endtask

  task automatic send(input int x, output int hs);
    int n = 0;
    s_data  = SW'(x);
    s_valid = 1'b1;
    while (s_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("s_ready_seen", 64'(s_ready), 64'd1);
    hs = cyc;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic collect(input int x[4], input string tag);
    for (int b = 0; b < NF; b++) begin
      wait_valid($sformatf("%s_b%0d", tag, b));
      check_bin(tag, x, b);
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic send_block(input int x[4], input bit gaps, input bit tp,
                            input string tag);
    int hs, prev;
    prev = 0;
    for (int i = 0; i < N; i++) begin
      if (gaps) repeat ($urandom_range(3)) @(negedge clk);
      send(x[i], hs);
      if (tp && i > 0)
        check({tag, "_tput"}, 64'(hs - prev), 64'(NF + 1));
      prev = hs;
    end
  endtask

  initial begin
    rst        = 1'b1;
    coef_valid = 1'b0;
    s_valid    = 1'b0;
    s_data     = '0;
    out_ready  = 1'b1;
    good_coefs();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_bin", 64'(out_bin), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_out_re", out_re, 64'd0);
    check("rst_out_im", out_im, 64'd0);
    check("rst_out_pwr", out_pwr, 64'd0);

    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_no_coef", 64'(s_ready), 64'd0);
    coef_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("coef_s_ready", 64'(s_ready), 64'd1);
    junk_coefs();

    xs = '{1, 1, 1, 1};
    send_block(xs, 1'b0, 1'b1, "dc");
    collect(xs, "dc");

    xs = '{1, 0, 0, 0};
    send_block(xs, 1'b0, 1'b0, "imp");
    collect(xs, "imp");

    for (int i = 0; i < N; i++)
      xs[i] = int'($urandom_range(16000)) - 8000;
    out_ready = 1'b0;
    send_block(xs, 1'b0, 1'b0, "bp");
    wait_valid("bp_b0");
    repeat (5) begin
      @(negedge clk);
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_s_ready", 64'(s_ready), 64'd0);
      check_bin("bp_hold", xs, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    nwait = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && nwait < 20) begin
      nwait++;
      @(negedge clk);
    end
    check("bp_gap", 64'(nwait), 64'd4);
    check_bin("bp", xs, 1);
    @(posedge clk);
    @(negedge clk);

    good_coefs();
    xs = '{7, -3, 0, 0};
    send_block(xs, 1'b0, 1'b0, "part");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    check("midrst_s_ready", 64'(s_ready), 64'd0);
    check("midrst_out_re", out_re, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    junk_coefs();
    xs = '{1, 1, 1, 1};
    send_block(xs, 1'b0, 1'b0, "midrst");
    collect(xs, "midrst");

    for (int r = 0; r < 2; r++) begin
      send_block(xs, 1'b1, 1'b0, $sformatf("b2b%0d", r));
      collect(xs, $sformatf("b2b%0d", r));
    end

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++)
        xs[i] = int'($urandom_range(16000)) - 8000;
      send_block(xs, r[0], !r[0], $sformatf("rnd%0d", r));
      collect(xs, $sformatf("rnd%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
